// File: rtl/sine_pkg.sv
// Shared constants for the sine sigma-delta DAC: word lengths, full-scale feedback and
// integrator saturation bounds.
package sine_pkg;

   localparam int unsigned WL_DEF   = 16;
   localparam int unsigned AW_GUARD = 4;
   localparam int unsigned AW_DEF   = WL_DEF + AW_GUARD;

   function automatic int unsigned aw_of(input int unsigned wl);
      return wl + AW_GUARD;
   endfunction

   // Feedback magnitude equals the full-scale input, 2^(wl-1).
   function automatic longint fb_full(input int unsigned wl);
      return longint'(1) <<< (wl - 1);
   endfunction

   function automatic longint sat_max(input int unsigned aw);
      return (longint'(1) <<< (aw - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int unsigned aw);
      return -(longint'(1) <<< (aw - 1));
   endfunction

endpackage

// File: rtl/sine_sd_dac_if.sv
// Sample handshake between the sine generator (master) and the sigma-delta DAC (slave).
interface sine_sd_dac_if;
   import sine_pkg::*;

   logic signed [WL_DEF-1:0] sample;
   logic                     sample_valid;
   logic                     sample_req;

   modport master (output sample, output sample_valid, input sample_req);
   modport slave  (input sample, input sample_valid, output sample_req);

endinterface

// File: rtl/sd_prescaler.sv
// Down-counting update-rate prescaler; tick fires when the count is zero and reloads from div.
module sd_prescaler (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [7:0] div_i,
   output logic       tick_o
);

   logic [7:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == 8'd0);

   // div is only sampled on reload, so mid-count changes wait for the next tick.
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = 8'd0;
      end else if (cnt_q == 8'd0) begin
         cnt_d = div_i;
      end else begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sine_sd_dac.sv
// Second-order sigma-delta modulator turning the signed sine sample stream into a 1-bit
// pulse-density output, with saturating integrators and a lock-step sample request strobe.
module sine_sd_dac
   import sine_pkg::*;
#(
   parameter int unsigned WL = WL_DEF,
   parameter int unsigned AW = aw_of(WL)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   input  logic [7:0]  div_i,
   input  logic [1:0]  shift_i,
   input  logic        sat_clr_i,
   output logic        pdm_out_o,
   output logic        sat_flag_o,
   sine_sd_dac_if.slave smp_if
);

   // Sums carry two guard bits so a single add/subtract can never wrap before clamping.
   localparam int unsigned SW = AW + 2;
   localparam logic signed [SW-1:0] FbPos = SW'(fb_full(WL));
   localparam logic signed [SW-1:0] SatHi = SW'(sat_max(AW));
   localparam logic signed [SW-1:0] SatLo = SW'(sat_min(AW));

   logic signed [WL-1:0] sample_q, sample_d;
   logic signed [AW-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
   logic signed [AW-1:0] acc1_n, acc2_n;
   logic signed [WL-1:0] x_shr;
   logic signed [SW-1:0] fb, sum1, sum2;
   logic                 pdm_q, pdm_d, req_q, req_d, sat_q, sat_d;
   logic                 tick, ydec, clamp1, clamp2;

   sd_prescaler u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en_i),
      .div_i  (div_i),
      .tick_o (tick)
   );

   always_comb begin
      sample_d = smp_if.sample_valid ? smp_if.sample : sample_q;

      ydec  = ~acc2_q[AW-1];
      fb    = ydec ? FbPos : -FbPos;
      x_shr = sample_q >>> shift_i;

      sum1   = SW'(acc1_q) + SW'(x_shr) - fb;
      clamp1 = (sum1 > SatHi) || (sum1 < SatLo);
      acc1_n = (sum1 > SatHi) ? SatHi[AW-1:0] : (sum1 < SatLo) ? SatLo[AW-1:0] : sum1[AW-1:0];

      sum2   = SW'(acc2_q) + SW'(acc1_n) - fb;
      clamp2 = (sum2 > SatHi) || (sum2 < SatLo);
      acc2_n = (sum2 > SatHi) ? SatHi[AW-1:0] : (sum2 < SatLo) ? SatLo[AW-1:0] : sum2[AW-1:0];

      acc1_d = acc1_q;
      acc2_d = acc2_q;
      pdm_d  = pdm_q;
      if (!en_i) begin
         acc1_d = '0;
         acc2_d = '0;
         pdm_d  = 1'b0;
      end else if (tick) begin
         acc1_d = acc1_n;
         acc2_d = acc2_n;
         pdm_d  = ydec;
      end

      req_d = tick;

      // A clamp on the same cycle as a clear keeps the flag set.
      sat_d = sat_q;
      if (sat_clr_i) begin
         sat_d = 1'b0;
      end
      if (tick && (clamp1 || clamp2)) begin
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q <= '0;
         acc1_q   <= '0;
         acc2_q   <= '0;
         pdm_q    <= 1'b0;
         req_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         sample_q <= sample_d;
         acc1_q   <= acc1_d;
         acc2_q   <= acc2_d;
         pdm_q    <= pdm_d;
         req_q    <= req_d;
         sat_q    <= sat_d;
      end
   end

   assign pdm_out_o         = pdm_q;
   assign sat_flag_o        = sat_q;
   assign smp_if.sample_req = req_q;

endmodule

// File: tb/tb_sine_sd_dac.sv
// Directed bench for sine_sd_dac: reset, zero/DC input, prescaler, saturation, enable,
// asynchronous reset and a slow sine stream.
module tb_sine_sd_dac;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       sat_clr = 1'b0;
   logic [7:0] div = 8'd0;
   logic [1:0] shift = 2'd0;
   logic       pdm;
   logic       sat;

   int checks = 0;
   int failures = 0;

   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   sine_sd_dac_if smp_if ();

   sine_sd_dac dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en),
      .div_i      (div),
      .shift_i    (shift),
      .sat_clr_i  (sat_clr),
      .pdm_out_o  (pdm),
      .sat_flag_o (sat),
      .smp_if     (smp_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_sample(input logic signed [15:0] v);
      en = 1'b0;
      step();
      smp_if.sample = v;
      smp_if.sample_valid = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      smp_if.sample = '0;
      smp_if.sample_valid = 1'b0;
      #7;
      checks++;
      if (pdm !== 1'b0) begin failures++; $display("FAIL reset_pdm got=%b want=0", pdm); end
      checks++;
      if (smp_if.sample_req !== 1'b0) begin
         failures++; $display("FAIL reset_req got=%b want=0", smp_if.sample_req);
      end
      checks++;
      if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b want=0", sat); end
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if (pdm !== 1'b0 || smp_if.sample_req !== 1'b0) begin
         failures++; $display("FAIL idle_outputs got=%b%b want=00", pdm, smp_if.sample_req);
      end
   endtask

   task automatic test_zero();
      div = 8'd0;
      shift = 2'd0;
      load_sample(16'sd0);
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (pdm !== pat[i%4] || smp_if.sample_req !== 1'b1) begin
            failures++;
            $display("FAIL zero_pattern[%0d] got pdm=%b req=%b want pdm=%b req=1",
                     i, pdm, smp_if.sample_req, pat[i%4]);
         end
      end
      checks++;
      if (sat !== 1'b0) begin failures++; $display("FAIL zero_sat got=%b want=0", sat); end
   endtask

   task automatic test_dc();
      int ones;
      load_sample(16'sd16384);
      en = 1'b1;
      ones = 0;
      repeat (1024) begin step(); ones += int'(pdm); end
      checks++;
      if (ones < 758 || ones > 778) begin
         failures++; $display("FAIL dc_pos ones=%0d want 768+-10", ones);
      end
      load_sample(-16'sd16384);
      en = 1'b1;
      ones = 0;
      repeat (1024) begin step(); ones += int'(pdm); end
      checks++;
      if (ones < 246 || ones > 266) begin
         failures++; $display("FAIL dc_neg ones=%0d want 256+-10", ones);
      end
   endtask

   task automatic test_prescaler();
      int ticks;
      logic exp_req;
      load_sample(16'sd0);
      div = 8'd3;
      en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step();
         exp_req = (i % 4 == 0);
         checks++;
         if (smp_if.sample_req !== exp_req || pdm !== pat[(i/4)%4]) begin
            failures++;
            $display("FAIL div3[%0d] got req=%b pdm=%b want req=%b pdm=%b",
                     i, smp_if.sample_req, pdm, exp_req, pat[(i/4)%4]);
         end
      end
      // Five ticks done; the count just reloaded to 3, so div=0 applies after it drains.
      div = 8'd0;
      for (int j = 0; j < 6; j++) begin
         step();
         exp_req = (j >= 3);
         ticks = 5 + ((j >= 3) ? j - 2 : 0);
         checks++;
         if (smp_if.sample_req !== exp_req || pdm !== pat[(ticks-1)%4]) begin
            failures++;
            $display("FAIL div_change[%0d] got req=%b pdm=%b want req=%b pdm=%b",
                     j, smp_if.sample_req, pdm, exp_req, pat[(ticks-1)%4]);
         end
      end
   endtask

   task automatic test_saturation();
      div = 8'd0;
      shift = 2'd0;
      load_sample(16'sd32767);
      en = 1'b1;
      repeat (4096) step();
      checks++;
      if (sat !== 1'b1) begin failures++; $display("FAIL sat_set got=%b want=1", sat); end
      en = 1'b0;
      step();
      checks++;
      if (sat !== 1'b1) begin failures++; $display("FAIL sat_hold_en_low got=%b want=1", sat); end
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      checks++;
      if (sat !== 1'b0) begin failures++; $display("FAIL sat_clr got=%b want=0", sat); end
      shift = 2'd2;
      en = 1'b1;
      repeat (4096) step();
      checks++;
      if (sat !== 1'b0) begin failures++; $display("FAIL sat_shift2 got=%b want=0", sat); end
      shift = 2'd0;
   endtask

   task automatic test_enable();
      load_sample(16'sd0);
      smp_if.sample_valid = 1'b0;
      smp_if.sample = 16'sh7abc;
      en = 1'b1;
      step();
      checks++;
      if (pdm !== 1'b1) begin failures++; $display("FAIL en_first got=%b want=1", pdm); end
      en = 1'b0;
      step();
      checks++;
      if (pdm !== 1'b0 || smp_if.sample_req !== 1'b0) begin
         failures++; $display("FAIL en_drop got=%b%b want=00", pdm, smp_if.sample_req);
      end
      step();
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (pdm !== pat[i%4]) begin
            failures++; $display("FAIL reenable[%0d] got=%b want=%b", i, pdm, pat[i%4]);
         end
      end
   endtask

   task automatic test_async_reset();
      load_sample(16'sd32767);
      en = 1'b1;
      repeat (40) step();
      checks++;
      if (sat !== 1'b1 || smp_if.sample_req !== 1'b1) begin
         failures++; $display("FAIL pre_reset got sat=%b req=%b want 11", sat, smp_if.sample_req);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pdm !== 1'b0 || smp_if.sample_req !== 1'b0 || sat !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got pdm=%b req=%b sat=%b want 000",
                  pdm, smp_if.sample_req, sat);
      end
      smp_if.sample_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (pdm !== pat[i%4]) begin
            failures++; $display("FAIL post_reset[%0d] got=%b want=%b", i, pdm, pat[i%4]);
         end
      end
   endtask

   task automatic test_sine();
      logic signed [15:0] tab [64];
      logic signed [15:0] sq, xrec;
      int     reqn, ones;
      longint xsum, fbsum, diff;
      for (int k = 0; k < 64; k++) begin
         tab[k] = 16'($rtoi(16384.0 * $sin(2.0 * 3.14159265358979 * k / 64.0)));
      end
      div = 8'd0;
      shift = 2'd0;
      load_sample(tab[0]);
      sq = tab[0];
      reqn = 0;
      ones = 0;
      xsum = 0;
      en = 1'b1;
      for (int t = 0; t < 1088; t++) begin
         xrec = sq;
         step();
         if (smp_if.sample_valid) sq = smp_if.sample;
         if (t >= 64) begin
            ones += int'(pdm);
            xsum += longint'(xrec);
            if ((t - 64) % 32 == 31) begin
               fbsum = 64'sd32768 * longint'(2 * ones - 32);
               diff = fbsum - xsum;
               if (diff < 0) diff = -diff;
               checks++;
               // 6% of the 65536 full-scale range, summed over a 32-tick window.
               if (diff > 64'sd125829) begin
                  failures++;
                  $display("FAIL sine_track t=%0d got avg=%0d want avg=%0d", t,
                           fbsum / 32, xsum / 32);
               end
               ones = 0;
               xsum = 0;
            end
         end
         smp_if.sample_valid = smp_if.sample_req;
         if (smp_if.sample_req) begin
            reqn++;
            smp_if.sample = tab[(reqn / 16) % 64];
         end
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero();
      test_dc();
      test_prescaler();
      test_saturation();
      test_enable();
      test_async_reset();
      test_sine();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
